// File: rtl/pu_enc.sv
// pu_enc: program encoder/loader for the pu core.
// Takes one symbolic instruction per valid/ready handshake, encodes it into
// the 16-bit instruction word the decoder consumes, and writes it into IMEM
// at consecutive addresses starting from 0. LI16 expands into LIL then LIH.
module pu_enc #(
  parameter int unsigned IADW      = 8,
  parameter int unsigned HALT_STOP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      kind,
  input  logic [1:0]      rw,
  input  logic [1:0]      ra,
  input  logic [1:0]      rb,
  input  logic [2:0]      aop,
  input  logic [15:0]     imm,
  output logic            iwe,
  output logic [IADW-1:0] iad,
  output logic [15:0]     iwd,
  output logic [IADW:0]   cnt,
  output logic            full,
  output logic            done,
  output logic            err
);

  localparam logic [3:0] K_NOP    = 4'd0;
  localparam logic [3:0] K_HALT   = 4'd1;
  localparam logic [3:0] K_CAL_R  = 4'd2;
  localparam logic [3:0] K_LM_R   = 4'd3;
  localparam logic [3:0] K_ADDI   = 4'd4;
  localparam logic [3:0] K_SUBI   = 4'd5;
  localparam logic [3:0] K_LIL    = 4'd6;
  localparam logic [3:0] K_LIH    = 4'd7;
  localparam logic [3:0] K_LM_ADD = 4'd8;
  localparam logic [3:0] K_LM_SUB = 4'd9;
  localparam logic [3:0] K_SM_ADD = 4'd10;
  localparam logic [3:0] K_SM_SUB = 4'd11;
  localparam logic [3:0] K_LI16   = 4'd12;

  // cnt value when memory is full, and when exactly one slot remains
  localparam logic [IADW:0] DEPTH_C = {1'b1, {IADW{1'b0}}};
  localparam logic [IADW:0] LAST_C  = {1'b0, {IADW{1'b1}}};

  typedef enum logic [0:0] {IDLE = 1'b0, EXP2 = 1'b1} state_t;

  state_t          state_q;
  logic            iwe_q;
  logic [IADW-1:0] iad_q;
  logic [15:0]     iwd_q;
  logic [IADW:0]   cnt_q;
  logic            done_q;
  logic            err_q;
  logic [15:0]     lih_q;    // second word of an LI16 macro, latched at accept

  logic            full_d;
  logic            accept_d;
  logic            illegal_d;
  logic [15:0]     word_d;

  // Single-word encodings; LI16 and illegal kinds are handled by the FSM.
  function automatic logic [15:0] encode_word(input logic [3:0]  k,
                                              input logic [1:0]  r_w,
                                              input logic [1:0]  r_a,
                                              input logic [1:0]  r_b,
                                              input logic [2:0]  op,
                                              input logic [7:0]  im);
    logic [15:0] w;
    w = 16'h0000;
    case (k)
      K_NOP:    w = 16'h0000;
      K_HALT:   w = 16'h0001;
      K_CAL_R:  w = {4'b0000, r_w, r_a, 1'b0, op, 1'b0, 1'b1, r_b};
      K_LM_R:   w = {4'b0001, r_w, r_a, 1'b0, op, 1'b0, 1'b1, r_b};
      K_ADDI:   w = {3'b001, 1'b0, r_w, r_a, im};
      K_SUBI:   w = {3'b001, 1'b1, r_w, r_a, im};
      K_LIL:    w = {4'b0100, r_w, r_a, im};
      K_LIH:    w = {4'b0101, r_w, r_a, im};
      K_LM_ADD: w = {3'b100, 1'b0, r_w, r_a, im};
      K_LM_SUB: w = {3'b100, 1'b1, r_w, r_a, im};
      K_SM_ADD: w = {3'b101, 1'b0, r_b, r_a, im};
      K_SM_SUB: w = {3'b101, 1'b1, r_b, r_a, im};
      default:  w = 16'h0000;
    endcase
    return w;
  endfunction

  // Handshake and encode decisions for the current cycle
  always_comb begin
    full_d    = (cnt_q == DEPTH_C);
    in_ready  = !rst && !clr && (state_q == IDLE) && !full_d &&
                !(done_q && (HALT_STOP != 0));
    accept_d  = in_valid && in_ready;
    illegal_d = (kind > K_LI16);
    word_d    = encode_word(kind, rw, ra, rb, aop, imm[7:0]);
  end

  // Loader FSM: one write per accepted instruction, two for LI16
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      iwe_q   <= 1'b0;
      iad_q   <= '0;
      iwd_q   <= 16'h0000;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      iwe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (illegal_d) begin
              err_q <= 1'b1;
            end else if (kind == K_LI16) begin
              // A split LI16 would leave a dangling LIL, so reject it whole
              if (cnt_q == LAST_C) begin
                err_q <= 1'b1;
              end else begin
                iwe_q   <= 1'b1;
                iad_q   <= cnt_q[IADW-1:0];
                iwd_q   <= {4'b0100, rw, rw, imm[7:0]};
                lih_q   <= {4'b0101, rw, rw, imm[15:8]};
                cnt_q   <= cnt_q + 1'b1;
                state_q <= EXP2;
              end
            end else begin
              iwe_q <= 1'b1;
              iad_q <= cnt_q[IADW-1:0];
              iwd_q <= word_d;
              cnt_q <= cnt_q + 1'b1;
              if (kind == K_HALT) begin
                done_q <= 1'b1;
              end
            end
          end
        end
        EXP2: begin
          iwe_q   <= 1'b1;
          iad_q   <= cnt_q[IADW-1:0];
          iwd_q   <= lih_q;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign iwe  = iwe_q;
  assign iad  = iad_q;
  assign iwd  = iwd_q;
  assign cnt  = cnt_q;
  assign full = full_d;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_pu_enc.sv
// Bench for pu_enc: an IADW=8 instance for encodings, LI16, illegal kinds,
// HALT and reset-in-EXP2, and an IADW=2 instance for the full/last-slot cases.
module tb_pu_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr8 = 1'b0, clr2 = 1'b0;
  logic        v8 = 1'b0, v2 = 1'b0;
  logic [3:0]  kind = 4'd0;
  logic [1:0]  rw = 2'd0, ra = 2'd0, rb = 2'd0;
  logic [2:0]  aop = 3'd0;
  logic [15:0] imm = 16'h0000;

  logic        rdy8, iwe8, full8, done8, err8;
  logic [7:0]  iad8;
  logic [15:0] iwd8;
  logic [8:0]  cnt8;
  logic        rdy2, iwe2, full2, done2, err2;
  logic [1:0]  iad2;
  logic [15:0] iwd2;
  logic [2:0]  cnt2;

  int checks = 0;
  int errors = 0;

  logic [23:0] q8[$];
  logic [23:0] q2[$];
  logic [23:0] e8, e2;

  always #5 clk = ~clk;

  pu_enc #(.IADW(8), .HALT_STOP(1)) dut8 (
    .clk(clk), .rst(rst), .clr(clr8), .in_valid(v8), .in_ready(rdy8),
    .kind(kind), .rw(rw), .ra(ra), .rb(rb), .aop(aop), .imm(imm),
    .iwe(iwe8), .iad(iad8), .iwd(iwd8), .cnt(cnt8), .full(full8),
    .done(done8), .err(err8));

  pu_enc #(.IADW(2), .HALT_STOP(1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .in_valid(v2), .in_ready(rdy2),
    .kind(kind), .rw(rw), .ra(ra), .rb(rb), .aop(aop), .imm(imm),
    .iwe(iwe2), .iad(iad2), .iwd(iwd2), .cnt(cnt2), .full(full2),
    .done(done2), .err(err2));

  // Scoreboard: every IMEM write must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (iwe8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL wr8_unexpected got iad=%0d iwd=%h, required no write", iad8, iwd8);
      end else begin
        e8 = q8.pop_front();
        if ({iad8, iwd8} !== e8) begin
          errors++;
          $display("FAIL wr8 got iad=%0d iwd=%h, required iad=%0d iwd=%h",
                   iad8, iwd8, e8[23:16], e8[15:0]);
        end
      end
    end
    if (iwe2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL wr2_unexpected got iad=%0d iwd=%h, required no write", iad2, iwd2);
      end else begin
        e2 = q2.pop_front();
        if ({6'd0, iad2, iwd2} !== e2) begin
          errors++;
          $display("FAIL wr2 got iad=%0d iwd=%h, required iad=%0d iwd=%h",
                   iad2, iwd2, e2[23:16], e2[15:0]);
        end
      end
    end
  end

  // Present one instruction and hold valid until accepted; returns #1 after the accept edge
  task automatic issue(input bit use2, input logic [3:0] k, input logic [1:0] w,
                       input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                       input logic [15:0] im);
    int n;
    n = 0;
    kind = k; rw = w; ra = a; rb = b; aop = op; imm = im;
    if (use2) v2 = 1'b1; else v8 = 1'b1;
    while (!(use2 ? rdy2 : rdy8) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout kind=%0d got in_ready=0, required 1", k);
    end
    @(posedge clk); #1;
    v8 = 1'b0; v2 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({iwe8, iad8, iwd8, cnt8, full8, done8, err8, rdy8} !== '0) begin
      errors++;
      $display("FAIL reset8 got iwe=%b iad=%0d iwd=%h cnt=%0d full=%b done=%b err=%b rdy=%b, required all 0",
               iwe8, iad8, iwd8, cnt8, full8, done8, err8, rdy8);
    end
    checks++;
    if ({iwe2, iad2, iwd2, cnt2, full2, done2, err2, rdy2} !== '0) begin
      errors++;
      $display("FAIL reset2 got iwe=%b cnt=%0d full=%b rdy=%b, required all 0", iwe2, cnt2, full2, rdy2);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b, required 1", rdy8);
    end
  endtask

  task automatic test_cal_r();
    q8.push_back({8'd0, 16'h0637});
    issue(0, 4'd2, 2'd1, 2'd2, 2'd3, 3'd3, 16'h0000);
    checks++;
    if (iwe8 !== 1'b1 || cnt8 !== 9'd1) begin
      errors++;
      $display("FAIL cal_r_timing got iwe=%b cnt=%0d, required iwe=1 cnt=1", iwe8, cnt8);
    end
  endtask

  task automatic test_li16();
    q8.push_back({8'd1, 16'h4AEF});
    q8.push_back({8'd2, 16'h5ABE});
    issue(0, 4'd12, 2'd2, 2'd0, 2'd0, 3'd0, 16'hBEEF);
    checks++;
    if (rdy8 !== 1'b0 || iwe8 !== 1'b1) begin
      errors++;
      $display("FAIL li16_exp2 got rdy=%b iwe=%b, required rdy=0 iwe=1", rdy8, iwe8);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy8 !== 1'b1 || iwe8 !== 1'b1 || cnt8 !== 9'd3) begin
      errors++;
      $display("FAIL li16_done got rdy=%b iwe=%b cnt=%0d, required rdy=1 iwe=1 cnt=3", rdy8, iwe8, cnt8);
    end
  endtask

  task automatic test_forms();
    q8.push_back({8'd3, 16'hBD05}); issue(0, 4'd11, 2'd0, 2'd1, 2'd3, 3'd0, 16'h0005);
    q8.push_back({8'd4, 16'h23FF}); issue(0, 4'd4,  2'd0, 2'd3, 2'd0, 3'd0, 16'h00FF);
    q8.push_back({8'd5, 16'h1C56}); issue(0, 4'd3,  2'd3, 2'd0, 2'd2, 3'd5, 16'h0000);
    q8.push_back({8'd6, 16'h3580}); issue(0, 4'd5,  2'd1, 2'd1, 2'd0, 3'd0, 16'hAA80);
    q8.push_back({8'd7, 16'h8B12}); issue(0, 4'd8,  2'd2, 2'd3, 2'd0, 3'd0, 16'h0012);
    q8.push_back({8'd8, 16'h0000}); issue(0, 4'd0,  2'd3, 2'd3, 2'd3, 3'd7, 16'hFFFF);
    q8.push_back({8'd9, 16'h5234}); issue(0, 4'd7,  2'd0, 2'd2, 2'd1, 3'd0, 16'h0034);
    checks++;
    if (cnt8 !== 9'd10) begin
      errors++;
      $display("FAIL forms_cnt got %0d, required 10", cnt8);
    end
  endtask

  task automatic test_illegal();
    issue(0, 4'hF, 2'd1, 2'd1, 2'd1, 3'd1, 16'h0011);
    checks++;
    if (err8 !== 1'b1 || iwe8 !== 1'b0 || cnt8 !== 9'd10) begin
      errors++;
      $display("FAIL illegal got err=%b iwe=%b cnt=%0d, required err=1 iwe=0 cnt=10", err8, iwe8, cnt8);
    end
    q8.push_back({8'd10, 16'h0000});
    issue(0, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000);
    checks++;
    if (err8 !== 1'b1 || cnt8 !== 9'd11) begin
      errors++;
      $display("FAIL after_illegal got err=%b cnt=%0d, required err=1 cnt=11", err8, cnt8);
    end
  endtask

  task automatic test_back_to_back();
    q8.push_back({8'd11, 16'h4534});
    q8.push_back({8'd12, 16'h5512});
    q8.push_back({8'd13, 16'h3A01});
    kind = 4'd12; rw = 2'd1; ra = 2'd0; rb = 2'd0; aop = 3'd0; imm = 16'h1234;
    v8 = 1'b1;
    @(posedge clk); #1;
    kind = 4'd5; rw = 2'd2; ra = 2'd2; imm = 16'h0001;
    checks++;
    if (rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall got rdy=%b, required 0", rdy8);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_resume got rdy=%b, required 1", rdy8);
    end
    @(posedge clk); #1;
    v8 = 1'b0;
    checks++;
    if (cnt8 !== 9'd14) begin
      errors++;
      $display("FAIL b2b_cnt got %0d, required 14", cnt8);
    end
  endtask

  task automatic test_full();
    q2.push_back({8'd0, 16'h0000}); issue(1, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000);
    q2.push_back({8'd1, 16'h0000}); issue(1, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000);
    q2.push_back({8'd2, 16'h0000}); issue(1, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000);
    issue(1, 4'd12, 2'd3, 2'd0, 2'd0, 3'd0, 16'h7777);
    checks++;
    if (err2 !== 1'b1 || iwe2 !== 1'b0 || cnt2 !== 3'd3 || rdy2 !== 1'b1) begin
      errors++;
      $display("FAIL li16_last_slot got err=%b iwe=%b cnt=%0d rdy=%b, required err=1 iwe=0 cnt=3 rdy=1",
               err2, iwe2, cnt2, rdy2);
    end
    q2.push_back({8'd3, 16'h0000}); issue(1, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000);
    checks++;
    if (full2 !== 1'b1 || rdy2 !== 1'b0 || cnt2 !== 3'd4) begin
      errors++;
      $display("FAIL full got full=%b rdy=%b cnt=%0d, required full=1 rdy=0 cnt=4", full2, rdy2, cnt2);
    end
    v2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v2 = 1'b0;
    clr2 = 1'b1;
    #1;
    checks++;
    if (rdy2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready got %b, required 0", rdy2);
    end
    @(posedge clk); #1;
    clr2 = 1'b0;
    #1;
    checks++;
    if (cnt2 !== 3'd0 || full2 !== 1'b0 || err2 !== 1'b0 || rdy2 !== 1'b1) begin
      errors++;
      $display("FAIL clr_state got cnt=%0d full=%b err=%b rdy=%b, required 0 0 0 1", cnt2, full2, err2, rdy2);
    end
    q2.push_back({8'd0, 16'h2407});
    issue(1, 4'd4, 2'd1, 2'd0, 2'd0, 3'd0, 16'h0007);
  endtask

  task automatic test_halt();
    q8.push_back({8'd14, 16'h0001});
    issue(0, 4'd1, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000);
    checks++;
    if (done8 !== 1'b1 || rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL halt got done=%b rdy=%b, required done=1 rdy=0", done8, rdy8);
    end
    v8 = 1'b1; kind = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    v8 = 1'b0;
    checks++;
    if (rdy8 !== 1'b0 || cnt8 !== 9'd15) begin
      errors++;
      $display("FAIL halt_stop got rdy=%b cnt=%0d, required rdy=0 cnt=15", rdy8, cnt8);
    end
    clr8 = 1'b1;
    @(posedge clk); #1;
    clr8 = 1'b0;
    #1;
    checks++;
    if (done8 !== 1'b0 || cnt8 !== 9'd0 || err8 !== 1'b0 || rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL halt_clr got done=%b cnt=%0d err=%b rdy=%b, required 0 0 0 1", done8, cnt8, err8, rdy8);
    end
  endtask

  task automatic test_rst_exp2();
    q8.push_back({8'd0, 16'h4F99});
    issue(0, 4'd12, 2'd3, 2'd0, 2'd0, 3'd0, 16'h1199);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({iwe8, iad8, iwd8, cnt8, full8, done8, err8, rdy8} !== '0) begin
      errors++;
      $display("FAIL rst_exp2 got iwe=%b iad=%0d iwd=%h cnt=%0d rdy=%b, required all 0",
               iwe8, iad8, iwd8, cnt8, rdy8);
    end
    rst = 1'b0;
    #1;
    q8.push_back({8'd0, 16'h2407});
    issue(0, 4'd4, 2'd1, 2'd0, 2'd0, 3'd0, 16'h0007);
  endtask

  initial begin
    test_reset();
    test_cal_r();
    test_li16();
    test_forms();
    test_illegal();
    test_back_to_back();
    test_full();
    test_halt();
    test_rst_exp2();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q8.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got pending8=%0d pending2=%0d, required 0 0", q8.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
